seq_div_unit: RTL
=================

Name: seq_div_unit

Overview:
- Multicycle signed divider that implements the MIPS DIV instruction.
- It is the responder side of the controller's divide interface: the control FSM issues divControl, waits for done or div0, then loads HI/LO through hidivControl/lodivControl.
- It uses restoring division on operand magnitudes, one quotient bit per cycle, followed by a sign fix-up.
- It sits beside the A/B operand registers and feeds the HI/LO register muxes.

Parameters:
- WIDTH, 32, operand, quotient and remainder width.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- divControl  input  2  command: 2'b01 = start signed divide; 2'b00, 2'b10 and 2'b11 = no operation.
- a  input  WIDTH  dividend (rs), sampled only on an accepted start.
- b  input  WIDTH  divisor (rt), sampled only on an accepted start.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse: hiOut/loOut hold a new result.
- div0  output  1  one-cycle pulse: divide-by-zero detected.
- hiOut  output  WIDTH  remainder; held until the next successful completion.
- loOut  output  WIDTH  quotient; held until the next successful completion.

Behaviour:
- Reset (reset=0, any time, including mid-operation):
  - State goes to IDLE.
  - busy=0, done=0, div0=0, hiOut=0, loOut=0, counter=0.
  - The internal quotient, remainder and operand registers are cleared.
- States: IDLE, CALC, FIX. All outputs are registered.
- IDLE:
  - Start is accepted when divControl==2'b01 at a rising edge.
  - If b==0: div0=1 for exactly the next cycle, state stays IDLE, busy stays 0, hiOut/loOut are unchanged, done stays 0.
  - Otherwise:
    - Latch |a| into the dividend shift register and |b| into the divisor register.
    - Record sign_q = a[WIDTH-1]^b[WIDTH-1] and sign_r = a[WIDTH-1].
    - Clear the partial remainder and set counter=0.
    - Set busy=1 and go to CALC.
- CALC, one iteration per edge:
  - Shift {rem,dvd} left by 1.
  - If rem >= divisor: rem = rem - divisor and the shifted-in quotient bit is 1; else the bit is 0.
  - Increment counter. After WIDTH iterations (counter==WIDTH) go to FIX.
- FIX:
  - loOut = sign_q ? -quotient : quotient.
  - hiOut = sign_r ? -remainder : remainder.
  - done=1 for one cycle, busy=0, return to IDLE.
- Latency: start accepted at edge E0 gives done high after edge E0+WIDTH+1, i.e. 33 edges later for WIDTH=32. busy is high from after E0 until done is asserted.
- Result semantics:
  - Quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
  - a = q*b + r always holds except in the overflow case below.
- Magnitudes are computed in WIDTH-bit unsigned arithmetic, so |-2^(WIDTH-1)| = 2^(WIDTH-1) is represented exactly.
- Overflow case -2^31 / -1: loOut=32'h80000000, hiOut=0, done pulses normally. No overflow flag is raised.
- divControl==2'b01 while busy is ignored. The in-flight operation completes unaffected, and a, b and sign latches are not disturbed.
- Changes on a or b after the start edge have no effect.
- done and div0 are never high in the same cycle.
- A new start is accepted in the same cycle done is high, since the unit is back in IDLE; the new operation's busy rises after that edge.
- A dividend of 0 gives loOut=0, hiOut=0, done after full latency. There is no early termination.

Test Plan:
- Positive divide: reset low 2 cycles then high; a=7, b=2, divControl=01 for one cycle → busy high for 33 cycles, then done pulse with loOut=3, hiOut=1.
- Signed cases:
  - a=-7 (FFFFFFF9), b=2 → loOut=FFFFFFFD, hiOut=FFFFFFFF.
  - a=7, b=-2 → loOut=FFFFFFFD, hiOut=1.
  - a=-7, b=-2 → loOut=3, hiOut=FFFFFFFF.
- Divide by zero: preload a result (100/7 → lo=14, hi=2), then a=5, b=0, start → div0 one-cycle pulse on the next cycle; done=0, busy=0, loOut=14 and hiOut=2 unchanged.
- Overflow: a=80000000, b=FFFFFFFF → loOut=80000000, hiOut=0, done pulses at normal latency.
- Ignored start: start 100/7; at cycle 10 drive divControl=01 with a=1, b=1 → exactly one done, at original latency, with loOut=14, hiOut=2; no second done follows.
- Reset mid-operation: start 1000/3, assert reset low at cycle 15 → all outputs 0 immediately, with no clock edge required; after release no done appears; a fresh 9/3 gives loOut=3, hiOut=0.

Source files
------------

// File: rtl/seq_div_unit.sv
// Multicycle signed divider for MIPS DIV: restoring division on operand magnitudes,
// one quotient bit per cycle, then sign fix-up into the HI (remainder) / LO (quotient) outputs.
module seq_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       divControl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hiOut,
    output logic [WIDTH-1:0] loOut
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_rem;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_busy;
    logic             r_done;
    logic             r_div0;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_start;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_calc_last;
    logic             w_busy_next;
    logic             w_done_next;
    logic             w_div0_next;

    assign w_start  = (divControl == 2'b01);
    assign w_b_zero = (b == '0);
    // Unsigned magnitudes: -2^(WIDTH-1) maps to 2^(WIDTH-1), which fits exactly.
    assign w_a_mag  = a[WIDTH-1] ? (-a) : a;
    assign w_b_mag  = b[WIDTH-1] ? (-b) : b;

    // One extra bit so the shifted partial remainder can never wrap before the compare.
    assign w_trial     = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff      = w_trial - {1'b0, r_divisor};
    assign w_ge        = (w_trial >= {1'b0, r_divisor});
    assign w_cnt_inc   = r_cnt + 1'b1;
    assign w_calc_last = (w_cnt_inc == CNT_W'(WIDTH));

    always_comb begin
        w_state_next = r_state;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
        w_div0_next  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    if (w_b_zero) begin
                        w_div0_next = 1'b1;
                    end else begin
                        w_state_next = CALC;
                        w_busy_next  = 1'b1;
                    end
                end
            end
            CALC: begin
                if (w_calc_last) begin
                    w_state_next = FIX;
                end
            end
            FIX: begin
                w_state_next = IDLE;
                w_busy_next  = 1'b0;
                w_done_next  = 1'b1;
            end
            default: begin
                w_state_next = IDLE;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_div0  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
            r_div0  <= w_div0_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dvd     <= '0;
            r_divisor <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start && !w_b_zero) begin
                        r_dvd     <= w_a_mag;
                        r_divisor <= w_b_mag;
                        r_rem     <= '0;
                        r_cnt     <= '0;
                        r_sign_q  <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_sign_r  <= a[WIDTH-1];
                    end
                end
                CALC: begin
                    r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
                    r_dvd <= {r_dvd[WIDTH-2:0], w_ge};
                    r_cnt <= w_cnt_inc;
                end
                FIX: begin
                    r_lo <= r_sign_q ? (-r_dvd) : r_dvd;
                    r_hi <= r_sign_r ? (-r_rem) : r_rem;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign div0  = r_div0;
    assign hiOut = r_hi;
    assign loOut = r_lo;

endmodule
